// File: rtl/uart_tx.sv
// uart_tx: serial transmitter for the APB UART.
// Sends start bit, 8 data bits LSB first, optional parity bit and one stop bit.
// Every output is a register loaded from next-state values, so txd never glitches.
module uart_tx #(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_enable,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    output logic       tx_data_out,
    output logic       busy,
    output logic       done
);

    // Clock cycles per bit; must be at least 2.
    localparam int DIV   = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             par, par_nxt;
    logic             txd_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             bit_end;

    // Parity over the byte; odd sense inverts the even result.
    function automatic logic calc_parity(input logic [7:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction

    assign bit_end = (cnt == CNT_LAST);

    // State, timing and datapath registers; reset takes priority and aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            tx_data_out <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            shreg       <= shreg_nxt;
            par         <= par_nxt;
            tx_data_out <= txd_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next-state logic; outputs are derived from the next state so they line up with it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        par_nxt   = par;
        done_nxt  = 1'b0;
        txd_nxt   = 1'b1;

        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                // Requests are only looked at here; anything during a frame is dropped.
                if (tx_start && tx_enable) begin
                    shreg_nxt = tx_data_in;
                    par_nxt   = calc_parity(tx_data_in);
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shreg_nxt[idx_nxt];
            PARITY:  txd_nxt = par_nxt;
            default: txd_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx with three parity configurations (DIV=16).
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int DIV = 16;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         at;
        bit         chain;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start = 3'b000;
    logic [2:0] en = 3'b000;
    logic [7:0] din0 = 8'h00;
    logic [7:0] din1 = 8'h00;
    logic [7:0] din2 = 8'h00;
    wire  [2:0] txd;
    wire  [2:0] busy;
    wire  [2:0] done;

    int   cyc = 0;
    logic rst_hit = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   dcnt[3] = '{0, 0, 0};
    int   dexp[3] = '{0, 0, 0};
    int   last_done[3] = '{0, 0, 0};
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    uart_tx #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en[0]), .tx_start(start[0]),
        .tx_data_in(din0), .tx_data_out(txd[0]), .busy(busy[0]), .done(done[0]));
    uart_tx #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en[1]), .tx_start(start[1]),
        .tx_data_in(din1), .tx_data_out(txd[1]), .busy(busy[1]), .done(done[1]));
    uart_tx #(.CLOCK_RATE(16), .BAUD_RATE(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_enable(en[2]), .tx_start(start[2]),
        .tx_data_in(din2), .tx_data_out(txd[2]), .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_hit <= !rst_n;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) dcnt[k] <= dcnt[k] + 1;
        end
    end

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic bit pop_exp(input int k, output exp_t e);
        e = '{data: 8'h00, par: 1'b0, at: -1, chain: 1'b0, abort: 1'b0};
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); return 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); return 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    function automatic int qsize(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Monitor: decodes each frame on txd[k] cycle by cycle against the scoreboard entry.
    task automatic mon(input int k);
        exp_t        e;
        logic [10:0] bits;
        int          nb;
        int          bad;
        bit          aborted;
        nb = (k == 0) ? 10 : 11;
        forever begin
            @(negedge clk);
            if (rst_hit !== 1'b0 || txd[k] !== 1'b0) continue;
            if (!pop_exp(k, e)) begin
                chk(1'b0, $sformatf("dut%0d_unexpected_frame", k), 1, 0);
                for (int i = 0; i < 400 && busy[k] !== 1'b0; i++) @(negedge clk);
                continue;
            end
            if (e.at >= 0) chk(cyc == e.at, $sformatf("dut%0d_start_latency", k), cyc, e.at);
            if (e.chain) chk(cyc == last_done[k] + 1, $sformatf("dut%0d_b2b_gap", k), cyc, last_done[k] + 1);
            bits = '1;
            bits[0] = 1'b0;
            bits[8:1] = e.data;
            if (k != 0) bits[9] = e.par;
            aborted = 1'b0;
            for (int b = 0; b < nb && !aborted; b++) begin
                bad = 0;
                for (int i = 0; i < DIV; i++) begin
                    if (b != 0 || i != 0) @(negedge clk);
                    if (rst_hit === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (txd[k] !== bits[b] || busy[k] !== 1'b1 || done[k] !== 1'b0) bad++;
                end
                if (!aborted)
                    chk(bad == 0, $sformatf("dut%0d_data%02h_bit%0d_bad_cycles", k, e.data, b), bad, 0);
            end
            if (aborted) begin
                chk(e.abort, $sformatf("dut%0d_unexpected_abort", k), 1, int'(e.abort));
                chk(txd[k] === 1'b1 && busy[k] === 1'b0 && done[k] === 1'b0,
                    $sformatf("dut%0d_reset_abort_txd_busy_done", k),
                    int'({txd[k], busy[k], done[k]}), 3'b100);
                continue;
            end
            if (e.abort) chk(1'b0, $sformatf("dut%0d_abort_missing", k), 0, 1);
            @(negedge clk);
            chk(done[k] === 1'b1 && busy[k] === 1'b0 && txd[k] === 1'b1,
                $sformatf("dut%0d_done_cycle_done_busy_txd", k),
                int'({done[k], busy[k], txd[k]}), 3'b101);
            last_done[k] = cyc;
        end
    endtask

    task automatic set_din(input int k, input logic [7:0] d);
        case (k)
            0:       din0 = d;
            1:       din1 = d;
            default: din2 = d;
        endcase
    endtask

    // Issue a one-cycle start request; called at a negedge, returns one negedge later.
    task automatic send(input int k, input logic [7:0] d, input logic p, input bit ab);
        exp_t e;
        set_din(k, d);
        en[k] = 1'b1;
        start[k] = 1'b1;
        e = '{data: d, par: p, at: cyc + 1, chain: 1'b0, abort: ab};
        push_exp(k, e);
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        while ((busy[k] !== 1'b0 || qsize(k) != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk(n < 600, $sformatf("dut%0d_idle_timeout", k), n, 600);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   t;
        int   dsave;
        bit   ok;
        exp_t e;

        fork
            mon(0);
            mon(1);
            mon(2);
        join_none

        // Reset held for 3 cycles with start requests present.
        rst_n = 1'b0;
        en = 3'b111;
        start = 3'b111;
        din0 = 8'hFF; din1 = 8'hFF; din2 = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            chk(txd === 3'b111 && busy === 3'b000 && done === 3'b000, "reset_outputs",
                int'({txd, busy, done}), 9'b111_000_000);
        end
        en = 3'b000;
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 3'b111 || busy !== 3'b000) ok = 1'b0;
        end
        chk(ok, "release_enable_low_line_high", int'(txd), 3'b111);
        start = 3'b000;
        @(negedge clk);

        // Basic frame, no parity.
        send(0, 8'hA5, 1'b0, 1'b0);
        dexp[0]++;
        wait_idle(0);

        // Parity frames: 0xA5 even -> 0, 0xA5 odd -> 1, 0x07 even -> 1.
        send(1, 8'hA5, 1'b0, 1'b0);
        dexp[1]++;
        wait_idle(1);
        send(2, 8'hA5, 1'b1, 1'b0);
        dexp[2]++;
        wait_idle(2);
        send(1, 8'h07, 1'b1, 1'b0);
        dexp[1]++;
        wait_idle(1);

        // Second request at cycle 40 of a 0x00 frame is ignored.
        t = cyc + 1;
        send(0, 8'h00, 1'b0, 1'b0);
        dexp[0]++;
        while (cyc < t + 40) @(negedge clk);
        din0 = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
        end
        chk(ok, "no_second_frame_after_ignored_start", int'(busy[0]), 0);

        // Start while disabled in IDLE is ignored.
        en[0] = 1'b0;
        din0 = 8'h0F;
        start[0] = 1'b1;
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) ok = 1'b0;
        end
        start[0] = 1'b0;
        chk(ok, "disabled_start_line_high", int'(txd[0]), 1);

        // Back-to-back frames with start held high.
        @(negedge clk);
        din0 = 8'h55;
        en[0] = 1'b1;
        start[0] = 1'b1;
        e = '{data: 8'h55, par: 1'b0, at: cyc + 1, chain: 1'b0, abort: 1'b0};
        push_exp(0, e);
        @(negedge clk);
        din0 = 8'h33;
        e = '{data: 8'h33, par: 1'b0, at: -1, chain: 1'b1, abort: 1'b0};
        push_exp(0, e);
        t = 0;
        while (done[0] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk(t < 400, "b2b_first_done_timeout", t, 400);
        @(negedge clk);
        start[0] = 1'b0;
        dexp[0] += 2;
        wait_idle(0);

        // Reset during data bit 3 aborts the frame without a done pulse.
        t = cyc + 1;
        send(0, 8'h3C, 1'b0, 1'b1);
        while (cyc < t + 16 + 3 * DIV + 6) @(negedge clk);
        dsave = dcnt[0];
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk(dcnt[0] == dsave, "no_done_after_abort", dcnt[0], dsave);
        chk(qsize(0) == 0 && busy[0] === 1'b0, "abort_consumed_and_idle", qsize(0), 0);
        send(0, 8'hC3, 1'b0, 1'b0);
        dexp[0]++;
        wait_idle(0);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk(dcnt[k] == dexp[k], $sformatf("dut%0d_done_pulse_count", k), dcnt[k], dexp[k]);
            chk(qsize(k) == 0, $sformatf("dut%0d_scoreboard_empty", k), qsize(k), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial transmit half of the APB-attached UART. It takes a byte and start strobe from the UART's APB interface logic and shifts out one asynchronous frame on txd: start bit, 8 data bits LSB first, optional parity bit, one stop bit. It reports busy and done back to the APB interface and pairs with the existing Receiver at the far end of the line, using matching framing.

Parameters:
CLOCK_RATE, 100000000, system clock frequency in Hz.
BAUD_RATE, 9600, line bit rate; DIV = CLOCK_RATE/BAUD_RATE (integer division), must be >= 2.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1; 0 = even, 1 = odd.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst_n  input  1  synchronous reset, active-low, sampled on the rising clk edge.
tx_enable  input  1  transmitter enable; gates acceptance of new frames only.
tx_start  input  1  start request; sampled only in IDLE.
tx_data_in  input  8  byte to send; captured on the accepting edge.
tx_data_out  output  1  serial line (txd); idles high.
busy  output  1  high while a frame is in progress.
done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, tx_data_out=1, busy=0, done=0, baud counter=0, bit index=0, shift register=0. Reset takes priority over everything. Mid-frame reset aborts the frame; the line is high after that edge and no done pulse follows.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_data_out=1, busy=0.
  - On an edge with tx_start=1 and tx_enable=1: latch tx_data_in into the shift register, compute parity = XOR(data) XOR PARITY_ODD, clear the counter, go to START.
  - tx_start while tx_enable=0 is ignored; no request is queued.
- Bit timing: each bit drives tx_data_out for exactly DIV clock cycles. The baud counter runs 0..DIV-1; the bit or state advances on the edge where counter==DIV-1, and the counter then wraps to 0.
- START: tx_data_out=0, busy=1. After DIV cycles go to DATA with bit index 0.
- DATA: tx_data_out = shift register bit[index], LSB first. The index increments every DIV cycles. After bit 7 completes, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx_data_out = latched parity bit for DIV cycles, then go to STOP.
- STOP: tx_data_out=1, busy=1 for DIV cycles. On the final edge go to IDLE and assert done for exactly the following cycle.
- done cycle: busy=0, state=IDLE. A tx_start (with tx_enable=1) sampled on that cycle's edge is accepted, so back-to-back frames have no idle gap beyond the done cycle.
- Latency: the first cycle of the start bit is the cycle after the accepting edge. Frame length is (10 + PARITY_EN)*DIV cycles from the first start-bit cycle to the last stop-bit cycle.
- tx_start, tx_data_in and tx_enable changes while busy=1 are ignored. Data is latched, and deasserting tx_enable mid-frame does not truncate the frame.
- All outputs are registered; tx_data_out is glitch-free.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with tx_start=1 -> tx_data_out=1, busy=0, done=0 throughout; after release with tx_enable=0, tx_data_out remains 1.
- Basic frame, CLOCK_RATE=16, BAUD_RATE=1 (DIV=16), PARITY_EN=0: tx_data_in=0xA5 with a one-cycle tx_start -> line 0 for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles. busy=1 for exactly 160 cycles; done pulses once, one cycle long.
- Parity: PARITY_EN=1, PARITY_ODD=0 with 0xA5 -> parity bit 0, frame 176 cycles. PARITY_ODD=1 with 0xA5 -> parity bit 1. PARITY_ODD=0 with 0x07 -> parity bit 1.
- Ignored requests: a second tx_start with 0xFF at cycle 40 of a 0x00 frame -> frame serializes 0x00 unchanged and no second frame starts. tx_start with tx_enable=0 in IDLE -> line stays high.
- Back-to-back: tx_start held high with tx_enable=1, data 0x55 then 0x33 -> the second start bit begins the cycle after the done pulse; two done pulses total.
- Mid-frame reset: rst_n=0 during DATA bit 3 -> tx_data_out=1 and busy=0 after that edge, no done pulse; after release, the next tx_start sends a complete, correct frame.
